// File: rtl/alu_exec_pkg.sv
// Shared constants for the EX-stage ALU: control codes, opcodes, funct fields, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_exec_pkg;

  // ALU control codes produced by the decoder.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b1001;
  localparam logic [3:0] ALU_MFLO = 4'b1010;

  // Main-decoder aluOp values.
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  // R-type funct fields.
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  // Execution FSM: single-cycle ops stay in IDLE, MULT iterates in MUL.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctr_dec.sv
// aluOp/funct to 4-bit ALU control decoder; MULT/MFHI/MFLO only with ALU_EXEC_MULT_EN.
// Latency: combinational.
// Backpressure: none.
module alu_ctr_dec
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctr_o
);

  // Unknown R-type functs fall back to AND.
  always_comb begin
    alu_ctr_o = ALU_AND;
    case (alu_op_i)
      OP_ADD: alu_ctr_o = ALU_ADD;
      OP_SUB: alu_ctr_o = ALU_SUB;
      OP_OR:  alu_ctr_o = ALU_OR;
      default: begin
        case (funct_i)
          FN_ADD:  alu_ctr_o = ALU_ADD;
          FN_SUB:  alu_ctr_o = ALU_SUB;
          FN_AND:  alu_ctr_o = ALU_AND;
          FN_OR:   alu_ctr_o = ALU_OR;
          FN_SLT:  alu_ctr_o = ALU_SLT;
`ifdef ALU_EXEC_MULT_EN
          FN_MULT: alu_ctr_o = ALU_MULT;
          FN_MFHI: alu_ctr_o = ALU_MFHI;
          FN_MFLO: alu_ctr_o = ALU_MFLO;
`endif
          default: alu_ctr_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// EX-stage ALU with registered result and iterative signed multiplier into HI/LO (ALU_EXEC_MULT_EN).
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULT.
// Backpressure: in_ready drops while a result is stalled or a multiply runs; outputs hold until taken.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       aluCtr,
  output logic             busy
);

  logic [3:0]       dec_ctr;
  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [3:0]       alu_ctr_q, alu_ctr_d;

`ifdef ALU_EXEC_MULT_EN
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;

  // Most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign mag_a    = srcA[WIDTH-1] ? -srcA : srcA;
  assign mag_b    = srcB[WIDTH-1] ? -srcB : srcB;
  assign prod     = neg_q ? -acc_q : acc_q;
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  // The final fixup cycle is not counted as multiply work.
  assign busy     = (state_q == ST_MUL) && (cnt_q != CNT_W'(WIDTH));
`else
  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign aluCtr    = alu_ctr_q;

  alu_ctr_dec u_dec (
    .alu_op_i  (aluOp),
    .funct_i   (funct),
    .alu_ctr_o (dec_ctr)
  );

  // Single-cycle execution of the decoded operation on the live operands.
  always_comb begin
    op_res = '0;
    case (dec_ctr)
      ALU_ADD:  op_res = srcA + srcB;
      ALU_SUB:  op_res = srcA - srcB;
      ALU_OR:   op_res = srcA | srcB;
      ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
`ifdef ALU_EXEC_MULT_EN
      ALU_MFHI: op_res = hi_q;
      ALU_MFLO: op_res = lo_q;
`endif
      default:  op_res = srcA & srcB;
    endcase
  end

  // Next state for the output handshake, FSM and shift-add multiplier.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    alu_ctr_d   = alu_ctr_q;
`ifdef ALU_EXEC_MULT_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      alu_ctr_d = dec_ctr;
`ifdef ALU_EXEC_MULT_EN
      if (dec_ctr == ALU_MULT) begin
        mcand_d  = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
        neg_d    = srcA[WIDTH-1] ^ srcB[WIDTH-1];
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ST_MUL;
      end else
`endif
      begin
        result_d    = op_res;
        zero_d      = (op_res == '0);
        out_valid_d = 1'b1;
      end
    end
`ifdef ALU_EXEC_MULT_EN
    if (state_q == ST_MUL) begin
      if (cnt_q != CNT_W'(WIDTH)) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end else begin
        hi_d        = prod[2*WIDTH-1:WIDTH];
        lo_d        = prod[WIDTH-1:0];
        result_d    = prod[WIDTH-1:0];
        zero_d      = (prod[WIDTH-1:0] == '0);
        out_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    end
`endif
  end

  // State register; reset discards any in-flight multiply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      alu_ctr_q   <= ALU_AND;
`ifdef ALU_EXEC_MULT_EN
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      alu_ctr_q   <= alu_ctr_d;
`ifdef ALU_EXEC_MULT_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed spec cases plus random ops against a reference model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a pending result.
module tb_alu_exec_seq;

  localparam int W = 32;

`ifdef ALU_EXEC_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [1:0]   aluOp;
  logic [5:0]   funct;
  logic [W-1:0] srcA, srcB, result;
  logic [3:0]   aluCtr;

  int total = 0;
  int bad   = 0;

  // Reference HI/LO as committed by completed multiplies.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_exec_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluOp     (aluOp),
    .funct     (funct),
    .srcA      (srcA),
    .srcB      (srcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .aluCtr    (aluCtr),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control code straight from the decode table.
  function automatic logic [3:0] model_ctr(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b011000: return MULT_EN ? 4'b1000 : 4'b0000;
      6'b010000: return MULT_EN ? 4'b1001 : 4'b0000;
      6'b010010: return MULT_EN ? 4'b1010 : 4'b0000;
      default:   return 4'b0000;
    endcase
  endfunction

  // Expected result, accept-to-valid latency and busy-cycle count; updates HI/LO on MULT.
  task automatic model_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat,
                          output int bsy);
    longint p;
    lat = 1;
    bsy = 0;
    case (model_ctr(op, fn))
      4'b0010: res = a + b;
      4'b0110: res = a - b;
      4'b0001: res = a | b;
      4'b0111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p    = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
        res  = m_lo;
        lat  = W + 1;
        bsy  = W;
      end
      4'b1001: res = m_hi;
      4'b1010: res = m_lo;
      default: res = a & b;
    endcase
  endtask

  // Issue one op with out_ready high and check result, flags, latency and busy time.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    int el, eb, lat, bc;
    model_op(op, fn, a, b, er, el, eb);
    out_ready = 1'b1;
    #1;
    check({tag, "/in_ready"}, in_ready, 1);
    aluOp = op; funct = fn; srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    srcA = $urandom; srcB = $urandom;
    lat = 1; bc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, el);
    check({tag, "/busy_cycles"}, bc, eb);
    check({tag, "/result"}, result, er);
    check({tag, "/zero"}, zero, (er == 0));
    check({tag, "/aluCtr"}, aluCtr, model_ctr(op, fn));
  endtask

  logic [5:0]  fn_tab [9];
  logic [1:0]  r_op;
  logic [5:0]  r_fn;
  logic [31:0] r_a, r_b;

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
               6'b011000, 6'b010000, 6'b010010, 6'b111111};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluOp = '0; funct = '0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/out_valid", out_valid, 0);
    check("reset/busy", busy, 0);
    check("reset/result", result, 0);
    check("reset/zero", zero, 0);
    check("reset/aluCtr", aluCtr, 0);
    rst_n = 1'b1;
    #1;
    check("reset/in_ready", in_ready, 1);

    run_op("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'h1);
    run_op("slt_neg_lt_pos", 2'b10, 6'b101010, 32'h8000_0000, 32'h1);
    run_op("slt_pos_lt_neg", 2'b10, 6'b101010, 32'h1, 32'h8000_0000);
    run_op("unknown_funct", 2'b10, 6'b111111, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op("sub", 2'b01, 6'h00, 32'h5, 32'h9);
    run_op("or_op", 2'b11, 6'h00, 32'h1200_0034, 32'h0056_7800);
    run_op("mult_m1x2", 2'b10, 6'b011000, 32'hFFFF_FFFF, 32'h2);
    run_op("mfhi", 2'b10, 6'b010000, 32'h0, 32'h0);
    run_op("mflo", 2'b10, 6'b010010, 32'h0, 32'h0);
    run_op("mult_minxmin", 2'b10, 6'b011000, 32'h8000_0000, 32'h8000_0000);
    run_op("mfhi_min", 2'b10, 6'b010000, 32'h3, 32'h3);
    run_op("mult_m3x5", 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'h5);
    run_op("mflo_m3x5", 2'b10, 6'b010010, 32'h0, 32'h0);
    run_op("mult_6x3", 2'b10, 6'b011000, 32'h6, 32'h3);

    // Backpressure: completed ADD held while the consumer stalls.
    aluOp = 2'b00; srcA = 32'd3; srcB = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp/out_valid", out_valid, 1);
    check("bp/result", result, 7);
    aluOp = 2'b01; srcA = 32'd10; srcB = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp/in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      check("bp/result_hold", result, 7);
      check("bp/valid_hold", out_valid, 1);
      check("bp/aluCtr_hold", aluCtr, 4'b0010);
    end
    out_ready = 1'b1;
    #1;
    check("bp/in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp/next_valid", out_valid, 1);
    check("bp/next_result", result, 6);
    check("bp/next_aluCtr", aluCtr, 4'b0110);

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_fn = fn_tab[$urandom_range(0, 8)];
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? r_a : 32'($urandom);
      run_op("random", r_op, r_fn, r_a, r_b);
    end

    // Reset in the middle of a multiply discards it and clears HI/LO.
    aluOp = 2'b10; funct = 6'b011000; srcA = 32'h7; srcB = 32'h9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0;
    check("midrst/out_valid", out_valid, 0);
    check("midrst/busy", busy, 0);
    check("midrst/result", result, 0);
    rst_n = 1'b1;
    #1;
    check("midrst/in_ready", in_ready, 1);
    run_op("midrst_mfhi", 2'b10, 6'b010000, 32'h5, 32'h3);
    run_op("midrst_mflo", 2'b10, 6'b010010, 32'h5, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Decodes aluOp/funct into a 4-bit ALU control code, executes the operation on WIDTH-bit operands, and returns a registered result over a valid/ready handshake.
- Adds an iterative signed multiplier that writes HI/LO registers, readable through MFHI and MFLO.
- Sits in the EX stage of the multi-cycle CPU, between the register-read latches and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- aluOp  input  2  main-decoder ALU opcode.
- funct  input  6  R-type function field.
- srcA  input  WIDTH  operand A.
- srcB  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- aluCtr  output  4  decoded control code of the last accepted op.
- busy  output  1  multiply in progress.

Behaviour:
- Decode (combinational, on the accept cycle):
  - aluOp 00 → 0010 ADD; aluOp 01 → 0110 SUB; aluOp 11 → 0001 OR.
  - aluOp 10, decoded from funct: 100000 → 0010 ADD; 100010 → 0110 SUB; 100100 → 0000 AND; 100101 → 0001 OR; 101010 → 0111 SLT; 011000 → 1000 MULT; 010000 → 1001 MFHI; 010010 → 1010 MFLO.
  - Any other funct → 0000 AND.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is signed compare, result 1 or 0 zero-extended.
  - MULT is signed WIDTH×WIDTH → 2·WIDTH; {HI,LO} = product.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready); back-to-back issue at one op per cycle is allowed.
  - out_valid, result, zero and aluCtr hold stable until out_valid && out_ready.
  - Inputs are ignored while in_ready = 0.
- FSM states: IDLE, MUL.
  - IDLE, accept of a non-MULT op: result registered at the next edge, out_valid=1 (latency 1). Remain in IDLE.
  - IDLE, accept of MULT: latch |srcA|, |srcB| and the product sign, clear the accumulator and cnt, go to MUL, busy=1.
  - MUL: one shift-add step per cycle. After WIDTH steps, apply the two's-complement sign fixup, write HI/LO, set result=LO, zero=(LO==0), out_valid=1, return to IDLE, busy=0. Accept-to-out_valid = WIDTH+1 cycles.
- Hazards and boundaries:
  - MFHI/MFLO return the HI/LO value committed by the most recent completed MULT; MULT is not accepted while out_valid is stalled.
  - Most-negative operand: magnitude taken as unsigned WIDTH bits; the product is still exact.
- Reset (rst_n=0 at a clock edge, in any state): state=IDLE, out_valid=0, result=0, zero=0, aluCtr=0000, busy=0, HI=0, LO=0, cnt=0. An in-flight multiply is discarded.
- A new MULT result never overwrites HI/LO before completion.

Optional Feature:
- Macro: ALU_EXEC_MULT_EN.
- Defined: MULT, MFHI and MFLO are decoded as above; MUL state, HI/LO and the counter are present.
- Undefined: funct 011000/010000/010010 decode to 0000 AND; the FSM stays in IDLE; busy is tied 0; no HI/LO storage. All other behaviour is unchanged.

Decomposition:
- Package alu_exec_pkg:
  - localparams for the ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULT, ALU_MFHI, ALU_MFLO).
  - funct constants.
  - FSM state encoding.
- Sub-module alu_ctr_dec: pure combinational aluOp/funct → aluCtr decoder, shared with the single-cycle datapath.
- The multiplier datapath stays inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-MULT → out_valid=0, busy=0, result=0, HI=LO=0; in_ready=1 on the first cycle after release.
- ADD wrap: aluOp=00, srcA=0xFFFFFFFF, srcB=1 → one cycle later result=0, zero=1, aluCtr=0010.
- SLT signed: aluOp=10, funct=101010, srcA=0x80000000, srcB=1 → result=1. Swap the operands → result=0. Unknown funct 111111 → result = srcA & srcB.
- MULT: srcA=0xFFFFFFFF (−1), srcB=2 → out_valid exactly 33 cycles after accept, LO=0xFFFFFFFE, HI=0xFFFFFFFF, busy high for 32 cycles. Follow with MFHI → 0xFFFFFFFF and MFLO → 0xFFFFFFFE.
- Backpressure: hold out_ready=0 with a completed ADD 3+4 pending → result stays 7, in_ready=0, a new request is not taken. Raise out_ready → the next op is accepted in the same cycle.
- With ALU_EXEC_MULT_EN undefined: funct=011000, srcA=6, srcB=3 → result=2 (AND) after 1 cycle, busy stays 0.
